// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//
// Decode-stage register scoreboard for an in-order RISC-V pipeline with
// forwarding. Every architectural register x1..x31 owns a small down-counter
// holding the number of cycles left before the value it is waiting for can
// be forwarded into EX. A decode instruction that reads a register whose
// counter is still running is held in IF/ID while a bubble goes into EX.
//
// Parameters:
//   LOAD_LAT  cycles from load issue until its result can be forwarded (1..8)
//   MUL_LAT   same latency for M-extension multiplies, funct3[2]=0 (1..16)
//   DIV_LAT   same latency for M-extension divide/remainder, funct3[2]=1 (1..16)
//   PERF_W    width of the stall performance counter
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   if_id_ir      instruction sitting in decode, 0 means bubble
//   mem_wait      whole pipeline frozen by memory this cycle
//   flush         decode instruction is being squashed this cycle
//   stall         hold IF/ID and inject a bubble into EX (combinational)
//   pending_mask  bit r set while register r still has a counter running
//   stall_count   saturating count of hazard stall cycles

module hazard_scoreboard #(
    parameter int LOAD_LAT = 2,
    parameter int MUL_LAT  = 3,
    parameter int DIV_LAT  = 8,
    parameter int PERF_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       if_id_ir,
    input  logic              mem_wait,
    input  logic              flush,
    output logic              stall,
    output logic [31:0]       pending_mask,
    output logic [PERF_W-1:0] stall_count
);

    localparam int MAX_LAT_LM = (LOAD_LAT > MUL_LAT) ? LOAD_LAT : MUL_LAT;
    localparam int MAX_LAT    = (MAX_LAT_LM > DIV_LAT) ? MAX_LAT_LM : DIV_LAT;
    // Counters only ever hold latency-1, so clog2(MAX_LAT) bits suffice.
    localparam int CW         = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    logic [CW-1:0] cnt      [1:31];
    logic [CW-1:0] cnt_next [1:31];
    logic [31:0]   busy;
    logic [31:0]   busy_next;

    logic [6:0]    opcode;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [4:0]    rd;
    logic          reads_rs1;
    logic          reads_rs2;
    logic          writes_rd;
    logic [CW-1:0] lat_m1;
    logic          hazard;
    logic          issue;

    assign opcode = if_id_ir[6:0];
    assign rs1    = if_id_ir[19:15];
    assign rs2    = if_id_ir[24:20];
    assign rd     = if_id_ir[11:7];

    // Which register fields are real operands for this opcode, and how long
    // the produced value takes before it can be forwarded.
    always_comb begin
        reads_rs1 = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
        reads_rs2 = (opcode == OP_REG || opcode == OP_STORE || opcode == OP_BRANCH);
        writes_rd = !(opcode == OP_STORE || opcode == OP_BRANCH);
        lat_m1    = '0;
        if (opcode == OP_LOAD) begin
            lat_m1 = CW'(LOAD_LAT - 1);
        end else if (opcode == OP_REG && if_id_ir[31:25] == F7_MULDIV) begin
            lat_m1 = if_id_ir[14] ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1);
        end
    end

    // x0 never has anything in flight, so its busy bit is hard-wired low.
    always_comb begin
        busy = '0;
        for (int r = 1; r < 32; r++) begin
            busy[r] = (cnt[r] != '0);
        end
    end

    always_comb begin
        hazard = (reads_rs1 && busy[rs1]) || (reads_rs2 && busy[rs2]);
        stall  = (if_id_ir != 32'd0) && !flush && hazard;
        issue  = (if_id_ir != 32'd0) && !stall && !mem_wait && !flush;
    end

    // A memory freeze holds every counter. Otherwise counters drain by one,
    // except the destination of an issuing instruction, which restarts from
    // its own latency so the youngest writer always wins.
    always_comb begin
        busy_next = '0;
        for (int r = 1; r < 32; r++) begin
            cnt_next[r] = cnt[r];
            if (!mem_wait) begin
                if (issue && writes_rd && rd == 5'(r)) begin
                    cnt_next[r] = lat_m1;
                end else if (cnt[r] != '0) begin
                    cnt_next[r] = cnt[r] - 1'b1;
                end
            end
            busy_next[r] = (cnt_next[r] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 1; r < 32; r++) begin
                cnt[r] <= '0;
            end
            pending_mask <= '0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                cnt[r] <= cnt_next[r];
            end
            pending_mask <= busy_next;
        end
    end

    // Only cycles lost to register hazards are counted; memory freezes are not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall && !mem_wait && stall_count != {PERF_W{1'b1}}) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter LOAD_LAT, default 2, meaning cycles from load issue until its result can be forwarded into EX (legal 1..8).
REQ-002 SHALL have parameter MUL_LAT, default 3, meaning the same latency for M-extension multiply ops, funct3[2]=0 (legal 1..16).
REQ-003 SHALL have parameter DIV_LAT, default 8, meaning the same latency for M-extension divide/remainder ops, funct3[2]=1 (legal 1..16).
REQ-004 SHALL have parameter PERF_W, default 32, meaning the stall performance counter width.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port rst_n  input  1  reset; one clock, asynchronous, active-low.
REQ-007 SHALL have port if_id_ir  input  32  instruction in decode; 0 means bubble.
REQ-008 SHALL have port mem_wait  input  1  pipeline frozen by memory this cycle.
REQ-009 SHALL have port flush  input  1  decode instruction is being squashed this cycle.
REQ-010 SHALL have port stall  output  1  hold IF/ID, inject bubble into EX (combinational).
REQ-011 SHALL have port pending_mask  output  32  bit r set when cnt[r] != 0 (registered).
REQ-012 SHALL have port stall_count  output  PERF_W  saturating count of hazard stall cycles.

Function
REQ-013 SHALL keep one down-counter cnt[r] per register r=1..31, width sized to max latency - 1; x0 has no counter and is never pending.
REQ-014 SHALL classify if_id_ir by opcode: 0000011 load; 0110011 with funct7=0000001 mul/div by funct3[2]; all other opcodes latency 1.
REQ-015 SHALL treat rs1 (ir[19:15]) as read for every opcode except 0110111 LUI, 0010111 AUIPC and 1101111 JAL.
REQ-016 SHALL treat rs2 (ir[24:20]) as read only for opcodes 0110011, 0100011 and 1100011.
REQ-017 SHALL treat rd (ir[11:7]) as written for every opcode except 0100011 and 1100011.
REQ-018 SHALL assert stall when if_id_ir != 0 and flush=0 and any read source s != 0 has cnt[s] != 0.
REQ-019 SHALL define issue = (if_id_ir != 0) & ~stall & ~mem_wait & ~flush.
REQ-020 SHALL, each clock with mem_wait=0, decrement every nonzero cnt by 1 (saturating at 0).
REQ-021 SHALL, on issue with written rd != 0, load cnt[rd] with latency-1 for its class, overriding that register's decrement and any prior value (WAW: newest wins).
REQ-022 SHALL, while mem_wait=1, hold all cnt values, perform no issue and still drive stall per REQ-018.
REQ-023 SHALL keep cnt unchanged by flush other than the normal decrement.
REQ-024 SHALL make a latency of 1 produce cnt=0, so a dependent instruction issues back-to-back with no stall.
REQ-025 SHALL increment stall_count on each clock where stall=1 and mem_wait=0, saturating at 2^PERF_W-1 with no wrap.
REQ-026 SHALL make pending_mask[0] constantly 0.

Reset
REQ-027 SHALL, while rst_n=0 and asynchronously on its falling edge, clear all cnt, pending_mask=0 and stall_count=0; stall then follows REQ-018 (0).
REQ-028 SHALL, on reset mid-stall, clear pending state so that the following decode instruction issues without stall.

Verification
REQ-029 SHALL check that with defaults, lw x5,0(x1) (0x0000A283) issued at cycle t followed by add x6,x5,x1 (0x00128333) gives stall=1 at t+1 only, the add issuing at t+2 with pending_mask[5]=1 at t+1 and 0 at t+2.
REQ-030 SHALL check that mul x7 issued at t, then sw x7,0(x2) (rs2 use), gives stall at t+1 and t+2, and stall_count advances by 2.
REQ-031 SHALL check that lw x0 followed by add x1,x0,x0 gives no stall and pending_mask=0; LUI x5 after lw x5 gives no stall.
REQ-032 SHALL check that div x9 (DIV_LAT=8) then add using x9 with mem_wait=1 for 3 cycles mid-stall extends the stall to 10 cycles total, with stall_count=7.
REQ-033 SHALL check that rst_n pulsed low at t+1 after lw x5 gives immediate pending_mask=0, stall=0, stall_count=0, and the dependent add issues at the first clock after release.
REQ-034 SHALL check, with PERF_W=4 and a sustained stall held by repeated divides, that stall_count saturates at 15 and holds.
